// File: rtl/countdown_timer_ctrl.sv
// RUN/PAUSE/DONE sequencer for an NDIG-digit BCD countdown timer.
// It uses a prescaled count tick and raises an alarm that returns to IDLE by itself.
module countdown_timer_ctrl #(
   parameter int NDIG        = 4,
   parameter int PRESCALE    = 1000,
   parameter int ALARM_TICKS = 8
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              load_i,
   input  logic [4*NDIG-1:0] preset_i,
   output logic [4*NDIG-1:0] cnt_o,
   output logic              tick_o,
   output logic              running_o,
   output logic              alarm_o,
   output logic [1:0]        state_o
);

   localparam int PW = $clog2(PRESCALE);
   localparam int AW = $clog2(ALARM_TICKS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [4*NDIG-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [AW-1:0]       alarm_cnt_q, alarm_cnt_d;
   logic                tick_q, tick_d;
   logic                running_q, alarm_q;
   logic [4*NDIG-1:0]   cnt_dec, preset_sat;

   // Ripple-borrow BCD decrement and per-digit saturation of the switch preset.
   always_comb begin : digit_comb
      logic borrow;
      borrow     = 1'b1;
      cnt_dec    = cnt_q;
      preset_sat = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (borrow) begin
            if (cnt_q[4*i +: 4] == 4'd0) begin
               cnt_dec[4*i +: 4] = 4'd9;
            end else begin
               cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
         preset_sat[4*i +: 4] = (preset_i[4*i +: 4] > 4'd9) ? 4'd9 : preset_i[4*i +: 4];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      presc_d     = presc_q;
      alarm_cnt_d = alarm_cnt_q;
      tick_d      = 1'b0;
      if (load_i) begin
         cnt_d       = preset_sat;
         presc_d     = '0;
         alarm_cnt_d = '0;
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!stop_i && start_i && (cnt_q != '0)) begin
                  state_d     = ST_RUN;
                  presc_d     = '0;
                  alarm_cnt_d = '0;
               end
            end
            ST_RUN: begin
               // STOP freezes the prescaler, even on the terminal cycle.
               if (stop_i) begin
                  state_d = ST_PAUSE;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  cnt_d   = cnt_dec;
                  tick_d  = 1'b1;
                  if (cnt_dec == '0) begin
                     state_d     = ST_DONE;
                     alarm_cnt_d = '0;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (!stop_i && start_i) begin
                  state_d     = ST_RUN;
                  alarm_cnt_d = '0;
               end
            end
            ST_DONE: begin
               if (start_i || stop_i) begin
                  state_d     = ST_IDLE;
                  cnt_d       = '0;
                  presc_d     = '0;
                  alarm_cnt_d = '0;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  if (alarm_cnt_q == ALARM_LAST) begin
                     state_d     = ST_IDLE;
                     alarm_cnt_d = '0;
                  end else begin
                     alarm_cnt_d = alarm_cnt_q + AW'(1);
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         presc_q     <= '0;
         alarm_cnt_q <= '0;
         tick_q      <= 1'b0;
         running_q   <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         presc_q     <= presc_d;
         alarm_cnt_q <= alarm_cnt_d;
         tick_q      <= tick_d;
         running_q   <= (state_d == ST_RUN);
         alarm_q     <= (state_d == ST_DONE);
      end
   end

   assign cnt_o     = cnt_q;
   assign tick_o    = tick_q;
   assign running_o = running_q;
   assign alarm_o   = alarm_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl (NDIG=2, PRESCALE=4, ALARM_TICKS=2).
// Each step pushes the expected {cnt,tick,running,alarm,state} and pops it after the edge.
module tb_countdown_timer_ctrl;

   localparam int W = 13;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic         stop;
   logic         load;
   logic [7:0]   preset;
   logic [7:0]   cnt;
   logic         tick;
   logic         running;
   logic         alarm;
   logic [1:0]   state;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_errors;

   countdown_timer_ctrl #(
      .NDIG        (2),
      .PRESCALE    (4),
      .ALARM_TICKS (2)
   ) dut (
      .clock_i   (clk),
      .reset_i   (reset_n),
      .start_i   (start),
      .stop_i    (stop),
      .load_i    (load),
      .preset_i  (preset),
      .cnt_o     (cnt),
      .tick_o    (tick),
      .running_o (running),
      .alarm_o   (alarm),
      .state_o   (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] pk(input logic [7:0] c, input logic t, input logic r,
                                       input logic a, input logic [1:0] s);
      return {c, t, r, a, s};
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] clamp(input logic [7:0] p);
      logic [3:0] hi, lo;
      hi = (p[7:4] > 4'd9) ? 4'd9 : p[7:4];
      lo = (p[3:0] > 4'd9) ? 4'd9 : p[3:0];
      return {hi, lo};
   endfunction

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got cnt=%h tick=%b run=%b alarm=%b state=%0d, want cnt=%h tick=%b run=%b alarm=%b state=%0d",
                  tag, act[12:5], act[4], act[3], act[2], act[1:0],
                  exp[12:5], exp[4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   task automatic step(input logic rst_v, input logic st, input logic sp, input logic ld,
                       input logic [7:0] pre, input logic [W-1:0] exp, input string tag);
      logic [W-1:0] e;
      @(negedge clk);
      reset_n = rst_v;
      start   = st;
      stop    = sp;
      load    = ld;
      preset  = pre;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard queue empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, {cnt, tick, running, alarm, state}, e);
      end
   endtask

   task automatic idle(input int n, input logic [W-1:0] exp, input string tag);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, exp, tag);
   endtask

   // Load 01 and run it down into DONE.
   task automatic run_to_done(input string tag);
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, pk(8'h01, 0, 0, 0, 0), tag);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h01, 0, 1, 0, 1), tag);
      idle(3, pk(8'h01, 0, 1, 0, 1), tag);
      idle(1, pk(8'h00, 1, 0, 1, 3), tag);
   endtask

   initial begin
      logic [7:0] pre_r;
      logic [7:0] exp8;
      int         v;
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      load     = 1'b0;
      preset   = 8'h00;

      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, pk(8'h00, 0, 0, 0, 0), "reset");

      // Count down 12 -> 08 with the 10 -> 09 borrow.
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h12, pk(8'h12, 0, 0, 0, 0), "load12");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h12, 0, 1, 0, 1), "start12");
      begin
         logic [7:0] seq [4];
         logic [7:0] prev;
         seq[0] = 8'h11; seq[1] = 8'h10; seq[2] = 8'h09; seq[3] = 8'h08;
         prev = 8'h12;
         for (int i = 0; i < 4; i++) begin
            idle(3, pk(prev, 0, 1, 0, 1), "run_gap");
            idle(1, pk(seq[i], 1, 1, 0, 1), "run_tick");
            prev = seq[i];
         end
      end

      // Terminal count, alarm, automatic return to IDLE after 8 cycles.
      run_to_done("done01");
      idle(7, pk(8'h00, 0, 0, 1, 3), "alarm_hold");
      idle(1, pk(8'h00, 0, 0, 0, 0), "alarm_auto_idle");

      // STOP on the terminal prescaler cycle, then resume from the held prescaler.
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, pk(8'h05, 0, 0, 0, 0), "load05");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h05, 0, 1, 0, 1), "start05");
      idle(3, pk(8'h05, 0, 1, 0, 1), "run05");
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, pk(8'h05, 0, 0, 0, 2), "stop_terminal");
      idle(5, pk(8'h05, 0, 0, 0, 2), "pause_hold");
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, pk(8'h05, 0, 0, 0, 2), "pause_stop");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h05, 0, 1, 0, 1), "resume");
      idle(1, pk(8'h04, 1, 1, 0, 1), "resume_tick");
      idle(1, pk(8'h04, 0, 1, 0, 1), "resume_after");

      // LOAD beats STOP and START; out-of-range digit saturates.
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3F, pk(8'h39, 0, 0, 0, 0), "load_priority");

      // START ignored at zero; STOP ignored in IDLE.
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, pk(8'h00, 0, 0, 0, 0), "load00");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h00, 0, 0, 0, 0), "start_at_zero");
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h27, pk(8'h27, 0, 0, 0, 0), "load27");
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, pk(8'h27, 0, 0, 0, 0), "idle_stop");

      // Leaving DONE via STOP, START and LOAD.
      run_to_done("done_stop");
      idle(1, pk(8'h00, 0, 0, 1, 3), "done_wait");
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, pk(8'h00, 0, 0, 0, 0), "done_stop_exit");
      run_to_done("done_start");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h00, 0, 0, 0, 0), "done_start_exit");
      run_to_done("done_load");
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, pk(8'h93, 0, 0, 0, 0), "done_load_exit");

      // Reset mid-run overrides a coincident START.
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, pk(8'h08, 0, 0, 0, 0), "load08");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h08, 0, 1, 0, 1), "start08");
      idle(3, pk(8'h08, 0, 1, 0, 1), "run08");
      idle(1, pk(8'h07, 1, 1, 0, 1), "tick07");
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h00, 0, 0, 0, 0), "reset_midrun");
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h00, 0, 0, 0, 0), "post_reset_start");

      // Random presets: saturation on load and one decrement with borrow.
      for (int k = 0; k < 12; k++) begin
         pre_r = 8'($urandom_range(0, 255));
         exp8  = clamp(pre_r);
         v     = int'(exp8[7:4]) * 10 + int'(exp8[3:0]);
         step(1'b1, 1'b0, 1'b0, 1'b1, pre_r, pk(exp8, 0, 0, 0, 0), "rand_load");
         if (v == 0) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(8'h00, 0, 0, 0, 0), "rand_start_zero");
         end else begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, pk(exp8, 0, 1, 0, 1), "rand_start");
            idle(3, pk(exp8, 0, 1, 0, 1), "rand_gap");
            if (v == 1) idle(1, pk(8'h00, 1, 0, 1, 3), "rand_done");
            else        idle(1, pk(to_bcd(v - 1), 1, 1, 0, 1), "rand_tick");
         end
      end

      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
